seq_counter: RTL and testbench
==============================

SEQ_COUNTER -- requirements
Module: seq_counter

Interface
REQ-001 SHALL have parameter N, default 4: width of limit, count and captured value.
REQ-002 SHALL have parameter W, default 4: width of the wrap counter.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rn_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clr_i, input, 1 bit: synchronous clear to IDLE.
REQ-006 SHALL have port start_i, input, 1 bit: latch configuration and begin a run.
REQ-007 SHALL have port e_i, input, 1 bit: count enable, one step per enabled cycle.
REQ-008 SHALL have port limit_i, input, N bits: terminal value, sampled only on start.
REQ-009 SHALL have port down_i, input, 1 bit: direction (1 = count limit down to 0), sampled only on start.
REQ-010 SHALL have port reload_i, input, 1 bit: auto-reload mode (1 = restart at terminal), sampled only on start.
REQ-011 SHALL have port count_o, output, N bits: current count.
REQ-012 SHALL have port tc_o, output, 1 bit: one-cycle terminal-count pulse.
REQ-013 SHALL have port seq_o, output, N bits: count value captured at the last terminal.
REQ-014 SHALL have port busy_o, output, 1 bit: high in RUN.
REQ-015 SHALL have port done_o, output, 1 bit: high in DONE.
REQ-016 SHALL have port wraps_o, output, W bits: terminals reached since start, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 Priority per edge SHALL be clr_i > start_i > e_i.
REQ-019 On start_i in any state: latch limit/down/reload; count_o <= (down ? limit : 0); wraps_o <= 0; state <= RUN; tc_o <= 0.
REQ-020 In RUN with e_i=1 and count_o != terminal (limit if up, 0 if down): count_o steps by +1 or -1; tc_o <= 0.
REQ-021 In RUN with e_i=1 and count_o == terminal: tc_o <= 1 for exactly one cycle; seq_o <= count_o; wraps_o increments and saturates at all-ones.
REQ-022 At terminal with reload=1: count_o reloads its start value; state stays RUN.
REQ-023 At terminal with reload=0: count_o holds; state <= DONE.
REQ-024 In RUN with e_i=0: all state holds; tc_o <= 0.
REQ-025 In DONE: hold count_o, seq_o and wraps_o; tc_o=0; e_i ignored; leave only via start_i or clr_i.
REQ-026 In IDLE: e_i ignored; count_o=0.
REQ-027 limit=0: the first enabled cycle in RUN SHALL be terminal in either direction.
REQ-028 Terminal compare and step SHALL be modulo 2^N with no carry out; limit=2^N-1 up SHALL reach all-ones without wrapping.
REQ-029 clr_i SHALL set state IDLE and zero count_o, seq_o, wraps_o and tc_o; latched config is don't-care.
REQ-030 start_i during RUN SHALL abort the run and restart per REQ-019 with no tc_o pulse.

Reset
REQ-031 rn_i low SHALL immediately force IDLE, count_o=0, seq_o=0, wraps_o=0, tc_o=0, busy_o=0, done_o=0, latched limit=0, down=0 and reload=0, independent of clk_i.
REQ-032 Reset assertion mid-run SHALL discard the run; the first edge after release SHALL behave as IDLE.

Structure
REQ-033 Shared package SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the defaults for N and W.
REQ-034 The wrap counter SHALL be sub-module sat_counter (parameter W; ports clk_i, rn_i, clr, inc, q), saturating at 2^W-1.

Verification
REQ-035 The bench SHALL apply up, one-shot: start with limit=3, e_i=1 -> count_o 0,1,2,3; tc_o pulses one cycle; seq_o=3; done_o=1; busy_o=0.
REQ-036 The bench SHALL apply down, reload: limit=2, 7 enabled cycles -> count_o 2,1,0,2,1,0,2; two tc_o pulses; wraps_o=2; busy_o stays 1.
REQ-037 The bench SHALL apply limit=0 up, one-shot -> tc_o on the first enabled cycle; seq_o=0; DONE.
REQ-038 The bench SHALL apply e_i toggling every other cycle with limit=2 -> tc_o only after 3 enabled cycles; count holds on idle cycles.
REQ-039 The bench SHALL assert clr_i and start_i together mid-run -> IDLE with all outputs 0; a start in the next cycle begins a new run cleanly.
REQ-040 The bench SHALL apply rn_i low between clock edges at count=2 -> outputs 0 immediately; W=2 reload with limit=0 then saturates wraps_o at 3.

Source files
------------

// File: rtl/seq_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter_pkg
//  Description : Shared definitions for the sequence counter: FSM state
//                encoding and default widths for the count and wrap counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_counter_pkg;

    // Default width of limit, count and captured terminal value.
    localparam int unsigned c_n_default = 4;
    // Default width of the saturating wrap counter.
    localparam int unsigned c_w_default = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : seq_counter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at all-ones.
//  Ports       : clk_i - clock (rising edge)
//                rn_i  - asynchronous active-low reset
//                clr   - synchronous clear to zero (wins over inc)
//                inc   - increment request
//                q     - current value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import seq_counter_pkg::*;
#(
    parameter int unsigned W = c_w_default
) (
    input  logic         clk_i,
    input  logic         rn_i,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] c_max = '1;
    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != c_max)) begin
            r_q <= r_q + c_one;
        end
    end

    assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter
//  Description : Up/down counter with a programmable terminal value, one-shot
//                or auto-reload mode, terminal pulse, captured terminal value
//                and a saturating count of terminals reached.
//  Ports       : clk_i    - clock (rising edge)
//                rn_i     - asynchronous active-low reset
//                clr_i    - synchronous clear to IDLE (highest priority)
//                start_i  - latch limit/down/reload and begin a run
//                e_i      - count enable, one step per enabled cycle in RUN
//                limit_i  - terminal value (sampled on start)
//                down_i   - 1 = count from limit down to 0 (sampled on start)
//                reload_i - 1 = restart at terminal (sampled on start)
//                count_o  - current count
//                tc_o     - one-cycle terminal-count pulse
//                seq_o    - count value captured at the last terminal
//                busy_o   - high in RUN
//                done_o   - high in DONE
//                wraps_o  - terminals reached since start, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_counter
    import seq_counter_pkg::*;
#(
    parameter int unsigned N = c_n_default,
    parameter int unsigned W = c_w_default
) (
    input  logic         clk_i,
    input  logic         rn_i,
    input  logic         clr_i,
    input  logic         start_i,
    input  logic         e_i,
    input  logic [N-1:0] limit_i,
    input  logic         down_i,
    input  logic         reload_i,
    output logic [N-1:0] count_o,
    output logic         tc_o,
    output logic [N-1:0] seq_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] wraps_o
);

    localparam logic [N-1:0] c_one = N'(1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_count;
    logic [N-1:0] w_count_nxt;
    logic [N-1:0] r_seq;
    logic [N-1:0] w_seq_nxt;
    logic [N-1:0] r_limit;
    logic [N-1:0] w_limit_nxt;
    logic         r_down;
    logic         w_down_nxt;
    logic         r_reload;
    logic         w_reload_nxt;
    logic         r_tc;
    logic         w_tc_nxt;
    logic         r_busy;
    logic         r_done;
    logic         w_wrap_clr;
    logic         w_wrap_inc;

    logic [N-1:0] w_terminal;
    logic [N-1:0] w_start_val;
    logic         w_at_term;

    // The run ends where it would start in the opposite direction, so the
    // terminal and the reload value are mirror images of each other.
    assign w_terminal  = r_down ? '0 : r_limit;
    assign w_start_val = r_down ? r_limit : '0;
    assign w_at_term   = (r_count == w_terminal);

    // ------------------------------------------------------------------
    // Next-state / datapath logic. Priority: clr_i > start_i > e_i.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_seq_nxt    = r_seq;
        w_limit_nxt  = r_limit;
        w_down_nxt   = r_down;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        w_wrap_clr   = 1'b0;
        w_wrap_inc   = 1'b0;

        if (clr_i) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_seq_nxt   = '0;
            w_wrap_clr  = 1'b1;
        end else if (start_i) begin
            // Also aborts a run in progress without a terminal pulse.
            w_limit_nxt  = limit_i;
            w_down_nxt   = down_i;
            w_reload_nxt = reload_i;
            w_count_nxt  = down_i ? limit_i : '0;
            w_wrap_clr   = 1'b1;
            w_state_nxt  = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (e_i) begin
                        if (w_at_term) begin
                            w_tc_nxt   = 1'b1;
                            w_seq_nxt  = r_count;
                            w_wrap_inc = 1'b1;
                            if (r_reload) begin
                                w_count_nxt = w_start_val;
                            end else begin
                                w_state_nxt = ST_DONE;
                            end
                        end else begin
                            // Modulo-2^N step; never reaches the carry since
                            // the terminal is always hit first.
                            w_count_nxt = r_down ? (r_count - c_one)
                                                 : (r_count + c_one);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE ignore e_i and hold everything.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rn_i) begin
        if (!rn_i) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_seq    <= '0;
            r_limit  <= '0;
            r_down   <= 1'b0;
            r_reload <= 1'b0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_seq    <= w_seq_nxt;
            r_limit  <= w_limit_nxt;
            r_down   <= w_down_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            // Status flags are registered alongside the state so they are
            // glitch-free flop outputs rather than a decode.
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    sat_counter #(
        .W (W)
    ) u_wraps (
        .clk_i (clk_i),
        .rn_i  (rn_i),
        .clr   (w_wrap_clr),
        .inc   (w_wrap_inc),
        .q     (wraps_o)
    );

    assign count_o = r_count;
    assign tc_o    = r_tc;
    assign seq_o   = r_seq;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule : seq_counter
`default_nettype wire

// File: tb/tb_seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_counter
//  Description : Self-checking bench for seq_counter. Two instances (W=4 and
//                W=2) share all inputs; every cycle their outputs are compared
//                with a behavioural model of the counting rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rn_i = 1'b0;
    logic         clr_i = 1'b0;
    logic         start_i = 1'b0;
    logic         e_i = 1'b0;
    logic [N-1:0] limit_i = '0;
    logic         down_i = 1'b0;
    logic         reload_i = 1'b0;

    logic [N-1:0] count_a, seq_a, count_b, seq_b;
    logic         tc_a, busy_a, done_a, tc_b, busy_b, done_b;
    logic [3:0]   wraps_a;
    logic [1:0]   wraps_b;

    always #5 clk = ~clk;

    seq_counter #(.N(N), .W(4)) dut_a (
        .clk_i(clk), .rn_i(rn_i), .clr_i(clr_i), .start_i(start_i), .e_i(e_i),
        .limit_i(limit_i), .down_i(down_i), .reload_i(reload_i),
        .count_o(count_a), .tc_o(tc_a), .seq_o(seq_a), .busy_o(busy_a),
        .done_o(done_a), .wraps_o(wraps_a)
    );

    seq_counter #(.N(N), .W(2)) dut_b (
        .clk_i(clk), .rn_i(rn_i), .clr_i(clr_i), .start_i(start_i), .e_i(e_i),
        .limit_i(limit_i), .down_i(down_i), .reload_i(reload_i),
        .count_o(count_b), .tc_o(tc_b), .seq_o(seq_b), .busy_o(busy_b),
        .done_o(done_b), .wraps_o(wraps_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers and flags.
    int m_count, m_seq, m_wraps4, m_wraps2, m_limit;
    bit m_tc, m_running, m_finished, m_down, m_reload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_seq = 0; m_wraps4 = 0; m_wraps2 = 0; m_limit = 0;
        m_tc = 0; m_running = 0; m_finished = 0; m_down = 0; m_reload = 0;
    endtask

    // Applies one clock edge worth of the counting rules using the inputs
    // that were present at that edge.
    task automatic model_edge();
        if (clr_i) begin
            m_running = 0; m_finished = 0;
            m_count = 0; m_seq = 0; m_wraps4 = 0; m_wraps2 = 0; m_tc = 0;
        end else if (start_i) begin
            m_limit = int'(limit_i); m_down = down_i; m_reload = reload_i;
            m_count = down_i ? int'(limit_i) : 0;
            m_wraps4 = 0; m_wraps2 = 0; m_tc = 0;
            m_running = 1; m_finished = 0;
        end else if (m_running && e_i) begin
            if (m_count == (m_down ? 0 : m_limit)) begin
                m_tc = 1;
                m_seq = m_count;
                if (m_wraps4 < 15) m_wraps4++;
                if (m_wraps2 < 3) m_wraps2++;
                if (m_reload) m_count = m_down ? m_limit : 0;
                else begin
                    m_running = 0;
                    m_finished = 1;
                end
            end else begin
                m_tc = 0;
                m_count = m_down ? (m_count + 15) % 16 : (m_count + 1) % 16;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count_a), 32'(m_count));
        chk({tag, ".tc"},    32'(tc_a),    32'(m_tc));
        chk({tag, ".seq"},   32'(seq_a),   32'(m_seq));
        chk({tag, ".busy"},  32'(busy_a),  32'(m_running));
        chk({tag, ".done"},  32'(done_a),  32'(m_finished));
        chk({tag, ".wraps"}, 32'(wraps_a), 32'(m_wraps4));
        chk({tag, ".count_w2"}, 32'(count_b), 32'(m_count));
        chk({tag, ".tc_w2"},    32'(tc_b),    32'(m_tc));
        chk({tag, ".wraps_w2"}, 32'(wraps_b), 32'(m_wraps2));
    endtask

    task automatic cycle(input string tag, input bit clr, input bit start, input bit e,
                         input int lim, input bit dn, input bit rl);
        clr_i = clr; start_i = start; e_i = e;
        limit_i = N'(lim); down_i = dn; reload_i = rl;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held from time 0.
        model_reset();
        #12;
        check_all("reset");
        #1 rn_i = 1'b1;

        // Idle: enable ignored.
        cycle("idle_e", 0, 0, 1, 7, 0, 0);

        // Up, one-shot, limit 3.
        cycle("up_start", 0, 1, 1, 3, 0, 0);
        for (int i = 0; i < 5; i++) cycle("up_run", 0, 0, 1, 3, 0, 0);
        chk("up_seq_final", 32'(seq_a), 32'd3);
        chk("up_done_final", 32'(done_a), 32'd1);
        chk("up_busy_final", 32'(busy_a), 32'd0);

        // Down, reload, limit 2, seven enabled cycles.
        cycle("dn_start", 0, 1, 0, 2, 1, 1);
        for (int i = 0; i < 7; i++) cycle("dn_run", 0, 0, 1, 2, 1, 1);
        chk("dn_wraps_final", 32'(wraps_a), 32'd2);
        chk("dn_busy_final", 32'(busy_a), 32'd1);

        // limit = 0 up, one-shot.
        cycle("z_start", 0, 1, 0, 0, 0, 0);
        cycle("z_run", 0, 0, 1, 0, 0, 0);
        chk("z_tc", 32'(tc_a), 32'd1);
        cycle("z_done", 0, 0, 1, 0, 0, 0);

        // Enable toggling, limit 2.
        cycle("tg_start", 0, 1, 0, 2, 0, 0);
        for (int i = 0; i < 8; i++) cycle("tg_run", 0, 0, (i % 2) == 1, 2, 0, 0);

        // Clear together with start mid-run, then a clean start.
        cycle("cs_start", 0, 1, 0, 9, 0, 1);
        cycle("cs_run", 0, 0, 1, 9, 0, 1);
        cycle("cs_run", 0, 0, 1, 9, 0, 1);
        cycle("cs_both", 1, 1, 1, 9, 0, 1);
        chk("cs_count_zero", 32'(count_a), 32'd0);
        cycle("cs_restart", 0, 1, 0, 4, 1, 0);
        cycle("cs_run2", 0, 0, 1, 4, 1, 0);

        // Start during RUN aborts with no pulse.
        cycle("ab_run", 0, 0, 1, 4, 1, 0);
        cycle("ab_start", 0, 1, 1, 15, 0, 0);

        // Full-range up count reaches all-ones without wrapping.
        for (int i = 0; i < 17; i++) cycle("full_run", 0, 0, 1, 15, 0, 0);

        // Asynchronous reset between edges at count = 2.
        cycle("rs_start", 0, 1, 0, 5, 0, 0);
        cycle("rs_run", 0, 0, 1, 5, 0, 0);
        cycle("rs_run", 0, 0, 1, 5, 0, 0);
        #2 rn_i = 1'b0;
        #1;
        model_reset();
        check_all("rs_async");
        #2 rn_i = 1'b1;
        cycle("rs_after", 0, 0, 1, 5, 0, 0);

        // Reload at limit 0: wraps saturate at 3 in the W=2 instance.
        cycle("sat_start", 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle("sat_run", 0, 0, 1, 0, 0, 1);
        chk("sat_w2_final", 32'(wraps_b), 32'd3);
        for (int i = 0; i < 12; i++) cycle("sat_run", 0, 0, 1, 0, 1, 1);
        chk("sat_w4_final", 32'(wraps_a), 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_counter
`default_nettype wire
